// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between two 32-bit requesters.
// Each 32-bit access is split into a low and/or high halfword phase (setup + access).
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_req/i_we[1:0]              per-port request and write flag
//   i_addr0/1, i_wdata0/1, i_be0/1  per-port byte address, write data, byte enables
//   o_gnt[1:0]                   combinational accept strobe (IDLE only)
//   o_rsp_vld[1:0], o_rdata      completion strobe and read data
//   o_busy                       arbiter not idle
//   SRAM_*                       SRAM address, data bus and active-low controls
module sram_arbiter #(
  parameter int unsigned WAIT_CYC = 1,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [31:0]       i_wdata0,
  input  logic [31:0]       i_wdata1,
  input  logic [3:0]        i_be0,
  input  logic [3:0]        i_be1,
  output logic [1:0]        o_gnt,
  output logic [1:0]        o_rsp_vld,
  output logic [31:0]       o_rdata,
  output logic              o_busy,
  output logic [ADDR_W-2:0] SRAM_ADDR,
  inout  wire  [15:0]       SRAM_DQ,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_LB_N,
  output logic              SRAM_UB_N
);

  localparam int unsigned WORD_W   = ADDR_W - 2;
  localparam logic [3:0]  ACC_LOAD = 4'(WAIT_CYC - 1);

  typedef enum logic [2:0] {IDLE, LO_SU, LO_ACC, HI_SU, HI_ACC, RESP} state_t;

  state_t              state, state_nxt;
  logic                rr_ptr;
  logic                win;
  logic                we_q, port_q;
  logic [WORD_W-1:0]   word_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [3:0]          cnt;
  logic [15:0]         rd_lo;
  logic                dq_oe;
  logic [15:0]         dq_out;

  logic                sel_we, cur_we, cur_port;
  logic [WORD_W-1:0]   sel_word, cur_word;
  logic [31:0]         sel_wdata, cur_wdata;
  logic [3:0]          sel_be, cur_be;

  logic                ce_n_d, oe_n_d, we_n_d, lb_n_d, ub_n_d, dq_oe_d, busy_d;
  logic [ADDR_W-2:0]   addr_d;
  logic [15:0]         dq_out_d;
  logic [1:0]          rsp_d;
  logic                is_phase, is_hi, is_acc;

  // Byte-offset bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr0[1:0], i_addr1[1:0]};

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  // Round-robin: on a tie the port that did not win last time is granted.
  always_comb begin
    win   = (i_req == 2'b11) ? ~rr_ptr : i_req[1];
    o_gnt = 2'b00;
    if (!i_rst && state == IDLE && i_req != 2'b00) o_gnt[win] = 1'b1;
  end

  // Winner's fields while IDLE, latched fields afterwards.
  always_comb begin
    sel_we    = i_we[win];
    sel_word  = win ? i_addr1[ADDR_W-1:2] : i_addr0[ADDR_W-1:2];
    sel_wdata = win ? i_wdata1 : i_wdata0;
    sel_be    = win ? i_be1 : i_be0;
    cur_we    = (state == IDLE) ? sel_we    : we_q;
    cur_word  = (state == IDLE) ? sel_word  : word_q;
    cur_wdata = (state == IDLE) ? sel_wdata : wdata_q;
    cur_be    = (state == IDLE) ? sel_be    : be_q;
    cur_port  = (state == IDLE) ? win       : port_q;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and next values of the registered SRAM/response outputs.
  always_comb begin
    state_nxt = state;
    ce_n_d    = 1'b1;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    lb_n_d    = 1'b1;
    ub_n_d    = 1'b1;
    dq_oe_d   = 1'b0;
    dq_out_d  = dq_out;
    addr_d    = SRAM_ADDR;
    rsp_d     = 2'b00;

    case (state)
      IDLE: begin
        if (o_gnt != 2'b00) begin
          if (!sel_we || sel_be[1:0] != 2'b00) state_nxt = LO_SU;
          else if (sel_be[3:2] != 2'b00)       state_nxt = HI_SU;
          else                                 state_nxt = RESP;
        end
      end
      LO_SU:  state_nxt = LO_ACC;
      LO_ACC: if (cnt == 4'd0) state_nxt = (we_q && be_q[3:2] == 2'b00) ? RESP : HI_SU;
      HI_SU:  state_nxt = HI_ACC;
      HI_ACC: if (cnt == 4'd0) state_nxt = RESP;
      RESP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    is_phase = state_nxt inside {LO_SU, LO_ACC, HI_SU, HI_ACC};
    is_hi    = state_nxt inside {HI_SU, HI_ACC};
    is_acc   = state_nxt inside {LO_ACC, HI_ACC};

    if (is_phase) begin
      addr_d = {cur_word, is_hi};
      ce_n_d = 1'b0;
      if (cur_we) begin
        // Data is driven from setup onward so it is stable before WE falls.
        we_n_d   = ~is_acc;
        lb_n_d   = ~(is_hi ? cur_be[2] : cur_be[0]);
        ub_n_d   = ~(is_hi ? cur_be[3] : cur_be[1]);
        dq_oe_d  = 1'b1;
        dq_out_d = is_hi ? cur_wdata[31:16] : cur_wdata[15:0];
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end

    if (state_nxt == RESP) rsp_d = {cur_port, ~cur_port};
    busy_d = (state_nxt != IDLE);
  end

  // Request latch, wait counter, read capture and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr    <= 1'b0;
      we_q      <= 1'b0;
      port_q    <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt       <= '0;
      rd_lo     <= '0;
      o_rdata   <= '0;
      o_rsp_vld <= '0;
      o_busy    <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      if (o_gnt != 2'b00) begin
        we_q    <= sel_we;
        word_q  <= sel_word;
        wdata_q <= sel_wdata;
        be_q    <= sel_be;
        port_q  <= win;
        rr_ptr  <= win;
      end
      if (state == LO_SU || state == HI_SU) cnt <= ACC_LOAD;
      else if (cnt != 4'd0)                 cnt <= cnt - 4'd1;
      // Low half is staged so o_rdata only changes when the read completes.
      if (state == LO_ACC && cnt == 4'd0 && !we_q) rd_lo <= SRAM_DQ;
      if (state == HI_ACC && cnt == 4'd0 && !we_q) o_rdata <= {SRAM_DQ, rd_lo};
      o_rsp_vld <= rsp_d;
      o_busy    <= busy_d;
      SRAM_ADDR <= addr_d;
      SRAM_CE_N <= ce_n_d;
      SRAM_OE_N <= oe_n_d;
      SRAM_WE_N <= we_n_d;
      SRAM_LB_N <= lb_n_d;
      SRAM_UB_N <= ub_n_d;
      dq_oe     <= dq_oe_d;
      dq_out    <= dq_out_d;
    end
  end

endmodule
